// File: rtl/adq_readout.sv
// Sequential readout of the sample memory from address 0, streamed over valid/ready.
// One word is in flight at a time: RD issues the read, WAIT captures it, SEND holds it.
module adq_readout #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADD_S  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_i,
    input  logic [ADD_S:0]    n_samples_i,
    output logic [ADD_S-1:0]  mem_add_o,
    output logic              mem_rd_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {StIdle, StRd, StWait, StSend, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADD_S-1:0]    add_q, add_d;
    logic [ADD_S:0]      len_q, len_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            add_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        add_d   = add_q;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (init_i) begin
                    len_d   = n_samples_i;
                    add_d   = '0;
                    state_d = (n_samples_i == '0) ? StDone : StRd;
                end
            end
            StRd: state_d = StWait;
            StWait: begin
                data_d  = mem_data_i;
                valid_d = 1'b1;
                // len_q is nonzero here, so len_q-1 cannot underflow
                last_d  = ({1'b0, add_q} == (len_q - (ADD_S + 1)'(1)));
                state_d = StSend;
            end
            StSend: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        add_d   = add_q + ADD_S'(1);
                        state_d = StRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_add_o   = add_q;
    assign mem_rd_o    = (state_q == StRd);
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign busy_o      = (state_q == StRd) || (state_q == StWait) || (state_q == StSend);
    assign done_o      = (state_q == StDone);

endmodule

// File: doc/adq_readout.md
Name: adq_readout

Overview:
- Playback/readout side of the acquisition system: after a capture run fills the sample memory, this block reads stored words back sequentially from address 0 and streams them out over a valid/ready handshake, e.g. to a DAC, UART or host link.
- Sits between the 256-word MEMORY read port and the downstream consumer.
- Mirrors the acquisition FSM: one owned address counter, a control FSM, and a completion flag (done) in place of ACK.

Parameters:
- DATA_W, 32, sample word width (matches MEMORY data width).
- ADD_S, 8, memory address width; depth = 2**ADD_S.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- init  in  1  start-readout pulse; sampled only in IDLE or DONE.
- n_samples  in  ADD_S+1  number of words to read (0..2**ADD_S); latched on accepted init.
- mem_add  out  ADD_S  memory read address.
- mem_rd  out  1  read strobe to memory; high for exactly one cycle per word.
- mem_data  in  DATA_W  memory read data; valid in the cycle after mem_rd (1-cycle registered read).
- out_data  out  DATA_W  streamed sample; held stable while out_valid && !out_ready.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge.
- out_last  out  1  high with out_valid on the final word of the run.
- busy  out  1  high in RD, WAIT and SEND.
- done  out  1  high in DONE; held until the next accepted init or rst.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-run): state=IDLE, mem_add=0, mem_rd=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, latched length=0.
- States: IDLE, RD, WAIT, SEND, DONE.
- IDLE, init=1:
  - latch n_samples; mem_add<=0.
  - If n_samples==0, go to DONE; otherwise go to RD.
- RD: mem_rd=1 (combinational from state) for one cycle with current mem_add; go to WAIT.
- WAIT: mem_data is valid this cycle; register out_data<=mem_data, out_valid<=1, out_last<=(mem_add==len-1); go to SEND.
- SEND: out_valid=1.
  - out_ready=0: stay; out_data and out_last stable.
  - Handshake, not last word: out_valid<=0, mem_add<=mem_add+1, go to RD.
  - Handshake on last word: out_valid<=0, out_last<=0, go to DONE.
- DONE: done=1, busy=0.
  - init=1: restart exactly as from IDLE (re-latch n_samples, mem_add<=0); done drops the next cycle.
  - Otherwise stay.
- init is ignored while busy. n_samples changes after latch have no effect.
- Latency: init edge to first out_valid = 3 cycles (RD, WAIT, then SEND asserted). Minimum per-word period = 3 cycles with out_ready tied high.
- Address wrap: n_samples=2**ADD_S reads addresses 0..2**ADD_S-1. mem_add never increments past len-1, so no wrap occurs. Values of n_samples above 2**ADD_S are not representable.
- rst has priority over init and every handshake. A word in flight at reset is dropped, with no out_valid afterwards.
- mem_rd is never asserted outside RD. The block never drives memory write.

Test Plan:
- Memory preloaded with word k = 0xFFFFFFFF-k for k=0..255; rst 1 cycle; init pulse with n_samples=4, out_ready=1 -> mem_rd pulses at add 0,1,2,3; words 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC, each accepted once; out_last only on the 4th; done=1 afterwards, busy=0.
- n_samples=256, out_ready=1 -> 256 transfers, the last being 0xFFFFFF00 at mem_add=255 with out_last=1; no access at address 0 after 255; total 768 cycles from first RD to DONE.
- n_samples=3, out_ready toggling 0,0,1 -> out_data/out_valid held stable across stall cycles; each word accepted exactly once; ordering preserved.
- n_samples=0 with init -> DONE the next cycle, no mem_rd, no out_valid.
- rst asserted during SEND of word 2 of 10 -> next cycle all outputs at reset values; new init with n_samples=2 restarts from address 0.
- init pulses while busy ignored (addresses unchanged); init while in DONE with n_samples=1 -> done drops, one word 0xFFFFFFFF streamed, done re-asserts.
